pc_status_sequencer: RTL and testbench

//  Sequencing register stage beside the per-class control decoders (B.cond, B, CBZ, ALU, LDUR ...).

---
 rtl/pc_status_sequencer.sv | 119 +++++++++++
 tb/tb_pc_status_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_status_sequencer.sv
// Program-counter / status / micro-state register stage that sits beside the control decoders.
// Optional feature: define PC_ALIGN_CHECK_EN to force word-aligned PC loads and raise a sticky pc_fault.
module pc_status_sequencer #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  CW_WIDTH = 29
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CW_WIDTH-1:0] controlWord,
    input  logic [PC_WIDTH-1:0] K,
    input  logic [PC_WIDTH-1:0] regA,
    input  logic [3:0]          aluStatus,
    input  logic [1:0]          nextState,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC4,
    output logic [3:0]          status,
    output logic [1:0]          state,
    output logic                pc_fault
);

    localparam logic [1:0] PSEL_HOLD   = 2'b00;
    localparam logic [1:0] PSEL_INC    = 2'b01;
    localparam logic [1:0] PSEL_REG    = 2'b10;
    localparam logic [1:0] PSEL_BRANCH = 2'b11;

    logic [1:0]          psel;
    logic                pc_sel;
    logic                sl;
    logic [PC_WIDTH-1:0] in_val;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]          status_q, status_d;
    logic [1:0]          state_q, state_d;

    // Only Psel, PCsel and SL matter here; the middle of the control word belongs to other stages.
    logic unused_cw_bits;
    assign unused_cw_bits = ^controlWord[CW_WIDTH-3:2];

    assign psel     = controlWord[CW_WIDTH-1:CW_WIDTH-2];
    assign pc_sel   = controlWord[1];
    assign sl       = controlWord[0];
    assign in_val   = pc_sel ? K : regA;
    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    always_comb begin
        target = pc_q;
        case (psel)
            PSEL_HOLD:   target = pc_q;
            PSEL_INC:    target = pc_plus4;
            PSEL_REG:    target = in_val;
            PSEL_BRANCH: target = pc_plus4 + (in_val << 2);
            default:     target = pc_q;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        pc_d     = pc_q;
        status_d = status_q;
        state_d  = state_q;
        fault_d  = fault_q;
        if (enable) begin
            pc_d     = {target[PC_WIDTH-1:2], 2'b00};
            status_d = sl ? aluStatus : status_q;
            state_d  = nextState;
            if (target[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign pc_fault = fault_q;
`else
    always_comb begin
        pc_d     = pc_q;
        status_d = status_q;
        state_d  = state_q;
        if (enable) begin
            pc_d     = target;
            status_d = sl ? aluStatus : status_q;
            state_d  = nextState;
        end
    end

    assign pc_fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            status_q <= 4'b0000;
            state_q  <= 2'b00;
        end else begin
            pc_q     <= pc_d;
            status_q <= status_d;
            state_q  <= state_d;
        end
    end

    assign PC     = pc_q;
    assign PC4    = pc_plus4;
    assign status = status_q;
    assign state  = state_q;

endmodule

// File: tb/tb_pc_status_sequencer.sv
// Directed bench for pc_status_sequencer: reset, sequencing, branches, BR alignment, flags, stall, wrap.
module tb_pc_status_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [28:0] controlWord;
    logic [63:0] K;
    logic [63:0] regA;
    logic [3:0]  aluStatus;
    logic [1:0]  nextState;
    logic [63:0] PC;
    logic [63:0] PC4;
    logic [3:0]  status;
    logic [1:0]  state;
    logic        pc_fault;

    int checks = 0;
    int errors = 0;
    logic exp_fault = 1'b0;

    pc_status_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .controlWord(controlWord),
        .K          (K),
        .regA       (regA),
        .aluStatus  (aluStatus),
        .nextState  (nextState),
        .PC         (PC),
        .PC4        (PC4),
        .status     (status),
        .state      (state),
        .pc_fault   (pc_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Middle bits carry junk to show they are ignored.
    task automatic set_ctrl(input logic [1:0] psel, input logic pcsel, input logic sl);
        controlWord = {psel, 25'h1ABCDEF, pcsel, sl};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [63:0] value);
        set_ctrl(2'b10, 1'b0, 1'b0);
        regA = value;
        tick();
        if (PC !== value) begin
            errors++;
            $display("[TB] FAIL load_pc: PC=%h expected %h", PC, value);
        end
        checks++;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; K = '0; regA = '0; aluStatus = '0; nextState = '0;
        set_ctrl(2'b00, 1'b0, 1'b0);
        #1;
        if (PC !== 64'h0 || status !== 4'h0 || state !== 2'h0 || pc_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL power_on_reset: PC=%h status=%b state=%0d fault=%b expected 0", PC, status, state, pc_fault);
        end
        checks++;
        @(negedge clock);
        reset = 1'b1;
        set_ctrl(2'b10, 1'b0, 1'b1);
        regA = 64'h40; nextState = 2'd2; aluStatus = 4'b1111;
        tick();
        if (PC !== 64'h40 || state !== 2'd2 || status !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL pre_reset_setup: PC=%h state=%0d status=%b expected 40/2/1111", PC, state, status);
        end
        checks++;
        set_ctrl(2'b00, 1'b0, 1'b0);
        nextState = 2'd0; aluStatus = 4'b0000;
        #1 reset = 1'b0;
        #1;
        if (PC !== 64'h0 || status !== 4'h0 || state !== 2'h0 || pc_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: PC=%h status=%b state=%0d fault=%b expected 0", PC, status, state, pc_fault);
        end
        checks++;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        set_ctrl(2'b01, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 64'(4 * i);
            if (PC !== exp_pc || PC4 !== exp_pc + 64'd4) begin
                errors++;
                $display("[TB] FAIL sequential_%0d: PC=%h PC4=%h expected %h/%h", i, PC, PC4, exp_pc, exp_pc + 64'd4);
            end
            checks++;
        end
    endtask

    task automatic test_branch();
        load_pc(64'h100);
        set_ctrl(2'b11, 1'b1, 1'b0);
        K = 64'hFFFF_FFFF_FFFF_FFFE;
        regA = 64'h1234;
        tick();
        if (PC !== 64'hFC) begin
            errors++;
            $display("[TB] FAIL bcond_taken: PC=%h expected 00000000000000fc", PC);
        end
        checks++;
        load_pc(64'h100);
        set_ctrl(2'b01, 1'b1, 1'b0);
        tick();
        if (PC !== 64'h104) begin
            errors++;
            $display("[TB] FAIL bcond_not_taken: PC=%h expected 0000000000000104", PC);
        end
        checks++;
        set_ctrl(2'b00, 1'b0, 1'b0);
        tick();
        if (PC !== 64'h104) begin
            errors++;
            $display("[TB] FAIL psel_hold: PC=%h expected 0000000000000104", PC);
        end
        checks++;
    endtask

    task automatic test_br();
        logic [63:0] exp_pc;
        set_ctrl(2'b10, 1'b0, 1'b0);
        K = 64'h7; regA = 64'h2000;
        tick();
        if (PC !== 64'h2000 || pc_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL br_aligned: PC=%h fault=%b expected 2000/0", PC, pc_fault);
        end
        checks++;
        regA = 64'h2002;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 64'h2000; exp_fault = 1'b1;
`else
        exp_pc = 64'h2002; exp_fault = 1'b0;
`endif
        if (PC !== exp_pc || pc_fault !== exp_fault) begin
            errors++;
            $display("[TB] FAIL br_misaligned: PC=%h fault=%b expected %h/%b", PC, pc_fault, exp_pc, exp_fault);
        end
        checks++;
        load_pc(64'h3000);
        if (pc_fault !== exp_fault) begin
            errors++;
            $display("[TB] FAIL fault_sticky: fault=%b expected %b", pc_fault, exp_fault);
        end
        checks++;
    endtask

    task automatic test_flags();
        set_ctrl(2'b01, 1'b0, 1'b1);
        aluStatus = 4'b0110;
        tick();
        if (status !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL flags_load: status=%b expected 0110", status);
        end
        checks++;
        set_ctrl(2'b01, 1'b0, 1'b0);
        aluStatus = 4'b1001;
        tick();
        if (status !== 4'b0110 || PC !== 64'h3008) begin
            errors++;
            $display("[TB] FAIL flags_hold: status=%b PC=%h expected 0110/3008", status, PC);
        end
        checks++;
    endtask

    task automatic test_stall();
        load_pc(64'h500);
        enable = 1'b0;
        set_ctrl(2'b11, 1'b1, 1'b1);
        K = 64'h5; aluStatus = 4'b1111; nextState = 2'd3;
        tick();
        tick();
        if (PC !== 64'h500 || status !== 4'b0110 || state !== 2'd0 || pc_fault !== exp_fault) begin
            errors++;
            $display("[TB] FAIL stall_hold: PC=%h status=%b state=%0d fault=%b expected 500/0110/0/%b", PC, status, state, pc_fault, exp_fault);
        end
        checks++;
        enable = 1'b1;
        tick();
        if (PC !== 64'h518 || status !== 4'b1111 || state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL stall_release: PC=%h status=%b state=%0d expected 518/1111/3", PC, status, state);
        end
        checks++;
    endtask

    task automatic test_wrap();
        nextState = 2'd1;
        load_pc(64'hFFFF_FFFF_FFFF_FFFC);
        if (PC4 !== 64'h0 || state !== 2'd1) begin
            errors++;
            $display("[TB] FAIL wrap_pc4: PC4=%h state=%0d expected 0/1", PC4, state);
        end
        checks++;
        set_ctrl(2'b01, 1'b0, 1'b0);
        tick();
        if (PC !== 64'h0) begin
            errors++;
            $display("[TB] FAIL wrap_inc: PC=%h expected 0", PC);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_br();
        test_flags();
        test_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
